// File: rtl/eth_pcs_params_pkg.sv
// ---------------------------------------------------------------------------
// eth_pcs_params
//   Shared constants and types for the 10GBASE-R style PCS datapath.
//   The block is carried as N_TRANS_PER_BLK payload words of W_DATA bits,
//   plus a W_SYNC-bit sync header.
//   Contents:
//     - block/word geometry (W_DATA, W_SYNC, N_TRANS_PER_BLK, W_TRANS_PER_BLK)
//     - SYNC_DATA: the data-block sync header value
//     - self-synchronising scrambler taps and default seed (1 + x^39 + x^58)
//     - PRBS31 taps and default seed (1 + x^28 + x^31)
//     - tx_mode_e: the per-block transmit pattern mode
// ---------------------------------------------------------------------------
package eth_pcs_params;

  localparam int W_DATA          = 32;
  localparam int W_SYNC          = 2;
  localparam int N_TRANS_PER_BLK = 2;
  localparam int W_TRANS_PER_BLK = (N_TRANS_PER_BLK > 1) ? $clog2(N_TRANS_PER_BLK) : 1;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;

  localparam int W_SCR_STATE = 58;
  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam logic [W_SCR_STATE-1:0] SCR_SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

  localparam int W_PRBS31     = 31;
  localparam int PRBS31_TAP   = 28;
  localparam logic [W_PRBS31-1:0] PRBS31_SEED_DEFAULT = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    TX_MODE_SCRAMBLE = 2'd0,
    TX_MODE_BYPASS   = 2'd1,
    TX_MODE_PRBS31   = 2'd2
  } tx_mode_e;

endpackage

// File: rtl/eth_pcs_prbs31_gen.sv
// ---------------------------------------------------------------------------
// eth_pcs_prbs31_gen
//   Fibonacci PRBS31 generator (1 + x^28 + x^31) producing W_DATA bits per
//   step, bit 0 being the earliest bit in time. Shared with the receive-side
//   PRBS checker.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous active-high reset, reloads SEED
//     i_adv    advance the LFSR by W_DATA bits at this edge
//     o_data   the W_DATA bits the current state produces (combinational)
// ---------------------------------------------------------------------------
module eth_pcs_prbs31_gen
  import eth_pcs_params::*;
#(
  parameter logic [W_PRBS31-1:0] SEED = PRBS31_SEED_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_adv,
  output logic [W_DATA-1:0] o_data
);

  logic [W_PRBS31-1:0] r_state;
  logic [W_PRBS31-1:0] w_state_next;

  // The state holds the last 31 sequence bits with bit 30 the most recent.
  // Extending that history by W_DATA bits with b[n] = b[n-31] ^ b[n-28]
  // yields this step's output word in its top bits, and its top 31 bits
  // become the next state.
  function automatic logic [W_PRBS31+W_DATA-1:0] prbs31_extend(
    input logic [W_PRBS31-1:0] state
  );
    logic [W_PRBS31+W_DATA-1:0] seq;
    seq = '0;
    seq[W_PRBS31-1:0] = state;
    for (int k = 0; k < W_DATA; k++) begin
      seq[W_PRBS31+k] = seq[k] ^ seq[k + (W_PRBS31 - PRBS31_TAP)];
    end
    return seq;
  endfunction

  logic [W_PRBS31+W_DATA-1:0] w_seq;

  always_comb begin
    w_seq        = prbs31_extend(r_state);
    o_data       = w_seq[W_PRBS31+W_DATA-1:W_PRBS31];
    w_state_next = w_seq[W_PRBS31+W_DATA-1:W_DATA];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SEED;
    end else if (i_adv) begin
      r_state <= w_state_next;
    end
  end

endmodule

// File: rtl/eth_pcs_scrambler.sv
// ---------------------------------------------------------------------------
// eth_pcs_scrambler
//   Transmit PCS stage after the 64b/66b encoder. Scrambles each payload word
//   with the self-synchronising 1 + x^39 + x^58 scrambler; the sync header
//   passes through. A per-block mode selects bypass or PRBS31 test pattern
//   instead (PRBS31 wins over bypass). One enabled cycle of latency.
//   Ports:
//     i_clk, i_reset   clock, synchronous active-high reset
//     i_clk_en         clock enable; all state holds when low
//     i_trans_cnt      transfer index within the block
//     i_sync_data      block sync header (sampled at transfer 0)
//     i_pld_data       payload word
//     i_scr_bypass     pass payload unscrambled (sampled at transfer 0)
//     i_prbs31_en      PRBS31 pattern output (sampled at transfer 0)
//     o_trans_cnt      transfer index aligned with the outputs
//     o_sync_data      sync header aligned with the output block
//     o_pld_data       scrambled / bypassed / PRBS payload word
// ---------------------------------------------------------------------------
module eth_pcs_scrambler
  import eth_pcs_params::*;
#(
  parameter logic [W_SCR_STATE-1:0] SCR_SEED    = SCR_SEED_DEFAULT,
  parameter logic [W_PRBS31-1:0]    PRBS31_SEED = PRBS31_SEED_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
  input  logic [W_SYNC-1:0]          i_sync_data,
  input  logic [W_DATA-1:0]          i_pld_data,
  input  logic                       i_scr_bypass,
  input  logic                       i_prbs31_en,
  output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
  output logic [W_SYNC-1:0]          o_sync_data,
  output logic [W_DATA-1:0]          o_pld_data
);

  // Offset into the scrambler state of the x^39 tap for output bit 0.
  // The x^58 tap for bit k is always state[k] since the state is exactly
  // 58 bits deep.
  localparam int TAP_A_OFS = W_SCR_STATE - SCR_TAP_A;
  localparam int TAP_B_OFS = W_SCR_STATE - SCR_TAP_B;

  logic [W_SCR_STATE-1:0]     r_scr;
  tx_mode_e                   r_mode;
  logic [W_SYNC-1:0]          r_sync;
  logic [W_TRANS_PER_BLK-1:0] r_trans_cnt;
  logic [W_SYNC-1:0]          r_sync_out;
  logic [W_DATA-1:0]          r_pld_out;

  logic                       w_blk_start;
  tx_mode_e                   w_req_mode;
  tx_mode_e                   w_mode;
  logic [W_SYNC-1:0]          w_sync;
  logic [W_DATA-1:0]          w_scr_word;
  logic [W_DATA-1:0]          w_prbs_word;
  logic                       w_prbs_adv;
  logic [W_SYNC-1:0]          w_sync_next;
  logic [W_DATA-1:0]          w_pld_next;

  // Mode and sync header are taken from the inputs on transfer 0 and from
  // the latched copies for the rest of the block, so transfer 0 already
  // uses the new block's settings.
  always_comb begin
    w_blk_start = (i_trans_cnt == '0);
    if (i_prbs31_en) begin
      w_req_mode = TX_MODE_PRBS31;
    end else if (i_scr_bypass) begin
      w_req_mode = TX_MODE_BYPASS;
    end else begin
      w_req_mode = TX_MODE_SCRAMBLE;
    end
    w_mode = w_blk_start ? w_req_mode : r_mode;
    w_sync = w_blk_start ? i_sync_data : r_sync;
  end

  // With only 32 output bits per word, both taps (k-39 and k-58) always
  // land in the stored history, so each word is a plain XOR of two
  // state slices with the payload.
  assign w_scr_word = i_pld_data
                    ^ r_scr[W_DATA-1+TAP_A_OFS:TAP_A_OFS]
                    ^ r_scr[W_DATA-1+TAP_B_OFS:TAP_B_OFS];

  assign w_prbs_adv = i_clk_en && (w_mode == TX_MODE_PRBS31);

  eth_pcs_prbs31_gen #(
    .SEED (PRBS31_SEED)
  ) u_prbs31_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_adv   (w_prbs_adv),
    .o_data  (w_prbs_word)
  );

  always_comb begin
    w_pld_next  = w_scr_word;
    w_sync_next = w_sync;
    case (w_mode)
      TX_MODE_BYPASS: begin
        w_pld_next = i_pld_data;
      end
      TX_MODE_PRBS31: begin
        w_pld_next  = w_prbs_word;
        w_sync_next = SYNC_DATA;
      end
      default: begin
        w_pld_next = w_scr_word;
      end
    endcase
  end

  // The scrambler history only moves when a word is actually scrambled, so
  // bypass and PRBS blocks leave the descrambler in the far end in step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scr       <= SCR_SEED;
      r_mode      <= TX_MODE_SCRAMBLE;
      r_sync      <= '0;
      r_trans_cnt <= '0;
      r_sync_out  <= '0;
      r_pld_out   <= '0;
    end else if (i_clk_en) begin
      r_mode      <= w_mode;
      r_sync      <= w_sync;
      r_trans_cnt <= i_trans_cnt;
      r_sync_out  <= w_sync_next;
      r_pld_out   <= w_pld_next;
      if (w_mode == TX_MODE_SCRAMBLE) begin
        r_scr <= {w_scr_word, r_scr[W_SCR_STATE-1:W_DATA]};
      end
    end
  end

  assign o_trans_cnt = r_trans_cnt;
  assign o_sync_data = r_sync_out;
  assign o_pld_data  = r_pld_out;

endmodule

// File: tb/tb_eth_pcs_scrambler.sv
// ---------------------------------------------------------------------------
// tb_eth_pcs_scrambler
//   Directed bench for eth_pcs_scrambler: reset values, the all-zero first
//   block, random traffic recovered through a bit-serial descrambler, the
//   bypass and PRBS31 modes, clock-enable gaps and mid-block reset.
// ---------------------------------------------------------------------------
module tb_eth_pcs_scrambler;
  import eth_pcs_params::*;

  logic                       i_clk = 1'b0;
  logic                       i_reset;
  logic                       i_clk_en;
  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt;
  logic [W_SYNC-1:0]          i_sync_data;
  logic [W_DATA-1:0]          i_pld_data;
  logic                       i_scr_bypass;
  logic                       i_prbs31_en;
  logic [W_TRANS_PER_BLK-1:0] o_trans_cnt;
  logic [W_SYNC-1:0]          o_sync_data;
  logic [W_DATA-1:0]          o_pld_data;

  int testCount = 0;
  int failCount = 0;

  // Descrambler history: descrHist[i] is the received bit i+1 bits ago.
  logic [57:0] descrHist;
  // PRBS reference history: prbsHist[i] is the sequence bit i+1 bits ago.
  logic [30:0] prbsHist;

  eth_pcs_scrambler dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clk_en     (i_clk_en),
    .i_trans_cnt  (i_trans_cnt),
    .i_sync_data  (i_sync_data),
    .i_pld_data   (i_pld_data),
    .i_scr_bypass (i_scr_bypass),
    .i_prbs31_en  (i_prbs31_en),
    .o_trans_cnt  (o_trans_cnt),
    .o_sync_data  (o_sync_data),
    .o_pld_data   (o_pld_data)
  );

  always #5 i_clk = ~i_clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic [W_TRANS_PER_BLK-1:0] trans,
                               input logic [1:0] sync, input logic [31:0] pld,
                               input logic bypass, input logic prbs,
                               input logic clkEn, input logic rst);
    i_trans_cnt  = trans;
    i_sync_data  = sync;
    i_pld_data   = pld;
    i_scr_bypass = bypass;
    i_prbs31_en  = prbs;
    i_clk_en     = clkEn;
    i_reset      = rst;
    @(posedge i_clk);
    #1;
  endtask

  // Bit-serial self-synchronising descrambler: d = o ^ o[-39] ^ o[-58].
  task automatic descramble(input logic [31:0] o, output logic [31:0] d);
    for (int k = 0; k < 32; k++) begin
      d[k] = o[k] ^ descrHist[38] ^ descrHist[57];
      descrHist = {descrHist[56:0], o[k]};
    end
  endtask

  // Bit-serial PRBS31 reference: b[n] = b[n-31] ^ b[n-28].
  task automatic nextPrbs(output logic [31:0] w);
    logic nb;
    for (int k = 0; k < 32; k++) begin
      nb = prbsHist[30] ^ prbsHist[27];
      w[k] = nb;
      prbsHist = {prbsHist[29:0], nb};
    end
  endtask

  initial begin
    logic [31:0] pld;
    logic [31:0] rec;
    logic [31:0] exp;
    logic [31:0] lastExp;
    logic [1:0]  sync;

    // Reset values.
    applyStimulus(1'b0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_pld", o_pld_data, 32'h0);
    checkOutput("reset_sync", 32'(o_sync_data), 32'h0);
    checkOutput("reset_trans", 32'(o_trans_cnt), 32'h0);

    // All-zero payload from the all-ones seed.
    applyStimulus(1'b0, 2'b10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_w0_pld", o_pld_data, 32'h0000_0000);
    checkOutput("zero_w0_sync", 32'(o_sync_data), 32'h2);
    checkOutput("zero_w0_trans", 32'(o_trans_cnt), 32'h0);
    applyStimulus(1'b1, 2'b10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("zero_w1_pld", o_pld_data, 32'h03FF_FF80);
    checkOutput("zero_w1_sync", 32'(o_sync_data), 32'h2);
    checkOutput("zero_w1_trans", 32'(o_trans_cnt), 32'h1);

    // Random scrambled traffic, recovered after the first block.
    descrHist = '0;
    for (int blk = 0; blk < 200; blk++) begin
      sync = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      for (int t = 0; t < N_TRANS_PER_BLK; t++) begin
        pld = $urandom;
        applyStimulus(W_TRANS_PER_BLK'(t), sync, pld, 1'b0, 1'b0, 1'b1, 1'b0);
        descramble(o_pld_data, rec);
        if (blk > 0) checkOutput("rand_recover", rec, pld);
        checkOutput("rand_sync", 32'(o_sync_data), 32'(sync));
        checkOutput("rand_trans", 32'(o_trans_cnt), 32'(t));
      end
    end

    // Bypass requested mid-block is ignored until the next block.
    pld = $urandom;
    applyStimulus(1'b0, 2'b01, pld, 1'b0, 1'b0, 1'b1, 1'b0);
    descramble(o_pld_data, rec);
    checkOutput("byp_pre_w0", rec, pld);
    pld = $urandom;
    applyStimulus(1'b1, 2'b01, pld, 1'b1, 1'b0, 1'b1, 1'b0);
    descramble(o_pld_data, rec);
    checkOutput("byp_midblk_scrambled", rec, pld);
    pld = $urandom;
    applyStimulus(1'b0, 2'b10, pld, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("byp_w0_pld", o_pld_data, pld);
    checkOutput("byp_w0_sync", 32'(o_sync_data), 32'h2);
    pld = $urandom;
    applyStimulus(1'b1, 2'b10, pld, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("byp_w1_pld", o_pld_data, pld);
    for (int t = 0; t < N_TRANS_PER_BLK; t++) begin
      pld = $urandom;
      applyStimulus(W_TRANS_PER_BLK'(t), 2'b01, pld, 1'b0, 1'b0, 1'b1, 1'b0);
      descramble(o_pld_data, rec);
      checkOutput("byp_resume_recover", rec, pld);
    end

    // PRBS31 from reset, with a clock-enable gap in the middle.
    applyStimulus(1'b0, 2'b10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("prbs_reset_pld", o_pld_data, 32'h0);
    prbsHist = '1;
    lastExp = '0;
    for (int blk = 0; blk < 6; blk++) begin
      for (int t = 0; t < N_TRANS_PER_BLK; t++) begin
        // Dropping the PRBS request on transfer 1 must not end the block.
        applyStimulus(W_TRANS_PER_BLK'(t), 2'b10, $urandom, 1'b0, (t == 0),
                      1'b1, 1'b0);
        nextPrbs(exp);
        if (blk == 0 && t == 0) checkOutput("prbs_first_word", o_pld_data, 32'h7000_0000);
        checkOutput("prbs_pld", o_pld_data, exp);
        checkOutput("prbs_sync", 32'(o_sync_data), 32'(SYNC_DATA));
        lastExp = exp;
      end
      if (blk == 2) begin
        for (int g = 0; g < 5; g++) begin
          applyStimulus(W_TRANS_PER_BLK'(g), 2'(g), $urandom, g[0], 1'b0,
                        1'b0, 1'b0);
          checkOutput("gap_pld", o_pld_data, lastExp);
          checkOutput("gap_sync", 32'(o_sync_data), 32'(SYNC_DATA));
          checkOutput("gap_trans", 32'(o_trans_cnt), 32'h1);
        end
      end
    end

    // Reset in the middle of a block, then the all-zero block again.
    applyStimulus(1'b0, 2'b10, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("midrst_pld", o_pld_data, 32'h0);
    checkOutput("midrst_sync", 32'(o_sync_data), 32'h0);
    checkOutput("midrst_trans", 32'(o_trans_cnt), 32'h0);
    applyStimulus(1'b0, 2'b01, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("postrst_w0_pld", o_pld_data, 32'h0000_0000);
    checkOutput("postrst_w0_sync", 32'(o_sync_data), 32'h1);
    applyStimulus(1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("postrst_w1_pld", o_pld_data, 32'h03FF_FF80);
    checkOutput("postrst_w1_sync", 32'(o_sync_data), 32'h1);

    // A non-zero transfer before the first block start carries sync 0.
    applyStimulus(1'b0, 2'b10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'b10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("orphan_sync", 32'(o_sync_data), 32'h0);
    checkOutput("orphan_pld", o_pld_data, 32'h0);
    checkOutput("orphan_trans", 32'(o_trans_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/eth_pcs_scrambler.md
Name: eth_pcs_scrambler

Overview:
- Transmit-path PCS stage directly downstream of the 64b/66b encoder.
- Takes one 32-bit payload word per transfer plus the block's 2-bit sync header, and applies the Clause 49 self-synchronising scrambler (G(x)=1+x^39+x^58) to the payload only. The sync header passes through unscrambled.
- Also provides a scrambler bypass and a PRBS31 test-pattern mode. Output feeds the gearbox/SerDes interface.

Parameters:
- SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded on reset; represents out[-58..-1].
- PRBS31_SEED, 31'h7FFF_FFFF, PRBS31 LFSR state loaded on reset; must be non-zero.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_clk_en  in  1  clock enable; all state, including output registers, holds when low
- i_trans_cnt  in  W_TRANS_PER_BLK  transfer index within the current block (0..N_TRANS_PER_BLK-1)
- i_sync_data  in  W_SYNC  sync header of the current block; stable across all of the block's transfers
- i_pld_data  in  W_DATA  payload word for transfer i_trans_cnt
- i_scr_bypass  in  1  1 = pass payload unscrambled
- i_prbs31_en  in  1  1 = PRBS31 test-pattern output
- o_trans_cnt  out  W_TRANS_PER_BLK  transfer index aligned with the outputs
- o_sync_data  out  W_SYNC  sync header aligned with the output block
- o_pld_data  out  W_DATA  scrambled / bypassed / PRBS payload word

Behaviour:
- Reset values:
  - o_trans_cnt=0, o_sync_data=0, o_pld_data=0.
  - Scrambler state=SCR_SEED, PRBS state=PRBS31_SEED.
  - Latched mode = normal scramble.
- Latency: exactly 1 enabled cycle (i_clk_en=1) from input to registered output. o_trans_cnt is i_trans_cnt delayed by the same amount.
- Bit order: bit 0 of each word is earliest in time. For k=0..31, out[k] = d[k] ^ out[k-39] ^ out[k-58], where negative indices read state history. After each scrambled word, state shifts by 32, with the new output word appended as the most recent bits.
- Sync: i_sync_data is sampled when i_trans_cnt==0 and held for the block. o_sync_data updates together with the o_pld_data of transfer 0.
- Mode latch: i_scr_bypass and i_prbs31_en are sampled only at enabled cycles with i_trans_cnt==0, and apply to the whole block. Mid-block changes are ignored until the next block. Precedence: PRBS31 > bypass > scramble.
- Scramble mode: payload is scrambled; scrambler state advances every enabled transfer.
- Bypass mode: o_pld_data=i_pld_data. Scrambler state holds.
- PRBS31 mode (P(x)=1+x^28+x^31, Fibonacci, 32 bits/transfer, bit 0 first):
  - o_pld_data = PRBS bits; o_sync_data forced to SYNC_DATA.
  - PRBS state advances only in this mode.
  - Scrambler state holds; i_pld_data is ignored.
- i_clk_en=0: no state change and outputs hold, regardless of other inputs.
- Reset during a block: everything returns to reset values on the next edge. The first block after reset must start at i_trans_cnt==0. Input words with i_trans_cnt!=0 before the first transfer-0 are scrambled in scramble mode but carry o_sync_data=0.
- i_trans_cnt is never ≥ N_TRANS_PER_BLK; no behaviour is defined for that case.

Decomposition:
- eth_pcs_params gains: SCR_SEED_DEFAULT, SCR_TAP_A=39, SCR_TAP_B=58, W_SCR_STATE=58, PRBS31_SEED_DEFAULT, PRBS31_TAP=28, W_PRBS31=31, and an enum for the latched tx pattern mode (SCRAMBLE/BYPASS/PRBS31).
- Uses the existing SYNC_DATA, W_DATA, W_SYNC, N_TRANS_PER_BLK and W_TRANS_PER_BLK.
- Sub-module eth_pcs_prbs31_gen: 31-bit LFSR with advance enable, producing 32 bits per step. Reused later by the receive-side PRBS checker.

Test Plan:
- Reset, scramble mode, all-zero payload, N_TRANS_PER_BLK=2 -> first block words 32'h0000_0000 then 32'h03FF_FF80 (bits 7..25 set); o_sync_data follows input.
- Random 200 blocks scrambled, fed through a reference descrambler model -> payload recovered bit-exact after the first block; sync headers unchanged and 1-cycle aligned.
- i_scr_bypass=1 asserted mid-block (i_trans_cnt=1) -> current block still scrambled; next block o_pld_data==i_pld_data; scrambler state unchanged when returning to scramble mode.
- i_prbs31_en=1 from reset -> output words match a PRBS31 reference from seed 31'h7FFF_FFFF; o_sync_data==SYNC_DATA; i_pld_data changes have no effect.
- i_clk_en held low for 5 cycles with toggling inputs -> outputs and states frozen; the stream resumes identically to a run without the gap.
- i_reset pulsed at i_trans_cnt=1 mid-packet -> outputs 0 next edge; the following block reproduces the first-block values of the all-zero test.
